// File: rtl/pwm_ref_compare_if.sv
// Duty-update handshake between the duty source (master) and the PWM comparator (slave).
interface pwm_ref_compare_if;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_ref_compare.sv
// PWM comparator: double-buffered duty, swapped only at the 20->0 wrap of the reference count.
// Optional complementary output with one-cycle dead time when PWM_COMPL_EN is defined.
module pwm_ref_compare #(
    parameter int PERIOD_MAX = 20,
    parameter int DUTY_MAX   = 21
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [4:0]       ref_cnt,
    pwm_ref_compare_if.slave duty_if,
    output logic             pwm_out,
`ifdef PWM_COMPL_EN
    output logic             pwm_out_n,
`endif
    output logic             period_start,
    output logic             duty_err
);

    localparam logic [4:0] LP_PERIOD_MAX = 5'(PERIOD_MAX);
    localparam logic [4:0] LP_DUTY_MAX   = 5'(DUTY_MAX);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_duty_act;
    logic [4:0] r_duty_pend;

    logic       w_bnd;
    logic       w_capture;
    logic       w_apply;
    logic       w_over;
    logic [4:0] w_duty_clamped;
    logic       w_cmp;

    // Counts above PERIOD_MAX never form a boundary; they just compare as-is.
    assign w_bnd          = en && (ref_cnt == LP_PERIOD_MAX);
    assign w_capture      = duty_if.duty_valid && (r_state == S_EMPTY);
    assign w_apply        = w_bnd && (r_state == S_FULL);
    assign w_over         = duty_if.duty_in > LP_DUTY_MAX;
    assign w_duty_clamped = w_over ? LP_DUTY_MAX : duty_if.duty_in;
    assign w_cmp          = ref_cnt < r_duty_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (duty_if.duty_valid) w_state_next = S_FULL;
            S_FULL:  if (w_bnd)              w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        duty_if.duty_ready = 1'b0;
        case (r_state)
            S_EMPTY: duty_if.duty_ready = 1'b1;
            default: duty_if.duty_ready = 1'b0;
        endcase
    end

    // A capture in the boundary cycle lands in pending; it waits for the next wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty_pend <= 5'd0;
            r_duty_act  <= 5'd0;
            duty_err    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_duty_pend <= w_duty_clamped;
                if (w_over) begin
                    duty_err <= 1'b1;
                end
            end
            if (w_apply) begin
                r_duty_act <= r_duty_pend;
            end
        end
    end

`ifdef PWM_COMPL_EN
    logic r_cmp_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_d      <= 1'b0;
            pwm_out      <= 1'b0;
            pwm_out_n    <= 1'b0;
            period_start <= 1'b0;
        end else begin
            r_cmp_d      <= w_cmp;
            pwm_out      <= w_cmp & r_cmp_d;
            pwm_out_n    <= ~w_cmp & ~r_cmp_d;
            period_start <= w_bnd;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= w_cmp;
            period_start <= w_bnd;
        end
    end
`endif

endmodule
